// File: rtl/regfile_dump_pkg.sv
// rtl/regfile_dump_pkg.sv - shared constants and FSM encoding for the register-file dump engine
package regfile_dump_pkg;

    // Register-file address width, shared with the register file itself
    localparam int REG_ADDR_W = 5;

    // Architectural register width
    localparam int DATA_W = 32;

    // Default number of architectural registers walked by a dump
    localparam int NUM_REGS_DEFAULT = 32;

    // Dump sequencer states: READ presents the address, SEND offers the captured word
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_FIN  = 2'd3
    } dump_state_t;

    // First register emitted: x0 is hard-wired zero on most cores, so it may be skipped
    function automatic logic [REG_ADDR_W-1:0] first_index(input int skip_x0);
        return (skip_x0 != 0) ? REG_ADDR_W'(1) : '0;
    endfunction

endpackage

// File: rtl/regfile_dump_if.sv
// rtl/regfile_dump_if.sv - output word stream of the register-file dump engine
interface regfile_dump_if;
    import regfile_dump_pkg::*;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_data;
    logic [REG_ADDR_W-1:0] out_index;
    logic                  out_last;

    // Producer side: the dump engine
    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    // Consumer side: whoever drains the dump
    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - walks the register file through its first read port and streams each register out
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEFAULT,
    parameter int SKIP_X0  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic [REG_ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0]     rf_data,
    regfile_dump_if.master        out_if,
    output logic                  busy,
    output logic                  done
);

    // Index range walked; the terminal compare against LAST_IDX means the
    // index never has to wrap, so plain 5-bit arithmetic is enough.
    localparam logic [REG_ADDR_W-1:0] FIRST_IDX = first_index(SKIP_X0);
    localparam logic [REG_ADDR_W-1:0] LAST_IDX  = REG_ADDR_W'(NUM_REGS - 1);

    dump_state_t           state_q, state_d;
    logic [REG_ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [REG_ADDR_W-1:0] oidx_q, oidx_d;
    logic                  last_q, last_d;

    // State, walk index and captured output word; reset clears all of them
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            oidx_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            oidx_q  <= oidx_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic: abort wins over everything outside IDLE, including a handshake
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        oidx_d  = oidx_q;
        last_d  = last_q;

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // start and abort together leave the engine idle
                    if (start && !abort) begin
                        state_d = ST_READ;
                        idx_d   = FIRST_IDX;
                    end
                end
                ST_READ: begin
                    // rf_data is combinational from rf_addr, so the word is
                    // captured in the same cycle the address is presented
                    data_d  = rf_data;
                    oidx_d  = idx_q;
                    last_d  = (idx_q == LAST_IDX);
                    state_d = ST_SEND;
                end
                ST_SEND: begin
                    if (out_if.out_ready) begin
                        if (last_q) begin
                            state_d = ST_FIN;
                        end else begin
                            idx_d   = idx_q + REG_ADDR_W'(1);
                            state_d = ST_READ;
                        end
                    end
                end
                ST_FIN: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Outputs are pure state decodes plus the captured word registers
    always_comb begin
        rf_addr          = idx_q;
        busy             = (state_q != ST_IDLE);
        done             = (state_q == ST_FIN);
        out_if.out_valid = (state_q == ST_SEND);
        out_if.out_data  = data_q;
        out_if.out_index = oidx_q;
        out_if.out_last  = last_q;
    end

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - self-checking bench for regfile_dump with and without x0 skipping
module tb_regfile_dump;
    import regfile_dump_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        start_s [2];
    logic        abort_s [2];
    logic        ready_s [2];
    logic [4:0]  addr_s  [2];
    logic [31:0] rfd_s   [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic        valid_s [2];
    logic [31:0] data_s  [2];
    logic [4:0]  oidx_s  [2];
    logic        last_s  [2];

    logic [31:0] rf_mem [2][32];
    logic [31:0] ref_rf [2][32];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    regfile_dump_if bus0 ();
    regfile_dump_if bus1 ();

    assign bus0.out_ready = ready_s[0];
    assign bus1.out_ready = ready_s[1];
    assign valid_s[0] = bus0.out_valid;
    assign valid_s[1] = bus1.out_valid;
    assign data_s[0]  = bus0.out_data;
    assign data_s[1]  = bus1.out_data;
    assign oidx_s[0]  = bus0.out_index;
    assign oidx_s[1]  = bus1.out_index;
    assign last_s[0]  = bus0.out_last;
    assign last_s[1]  = bus1.out_last;
    assign rfd_s[0]   = rf_mem[0][addr_s[0]];
    assign rfd_s[1]   = rf_mem[1][addr_s[1]];

    regfile_dump #(.NUM_REGS(32), .SKIP_X0(0)) dut0 (
        .clk(clk), .reset(reset), .start(start_s[0]), .abort(abort_s[0]),
        .rf_addr(addr_s[0]), .rf_data(rfd_s[0]), .out_if(bus0),
        .busy(busy_s[0]), .done(done_s[0])
    );

    regfile_dump #(.NUM_REGS(32), .SKIP_X0(1)) dut1 (
        .clk(clk), .reset(reset), .start(start_s[1]), .abort(abort_s[1]),
        .rf_addr(addr_s[1]), .rf_data(rfd_s[1]), .out_if(bus1),
        .busy(busy_s[1]), .done(done_s[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, st, ab, rdy;
        logic        exp_busy, exp_valid, exp_done;
        logic [4:0]  exp_addr;
        logic        chk_out;
        logic [31:0] exp_data;
        logic [4:0]  exp_index;
        logic        exp_last;
    } vec_t;

    vec_t tbl [9];

    // One dump on DUT w; checks every offered word against the reference register contents.
    task automatic run_dump(input int w, input int first, input bit rand_rdy, input int stall_at,
                            input int abort_at, input int reset_at, input bit wr5);
        int exp_idx, n, first_n, words, stall_cnt;
        bit ended, prev_stall, hs_last;
        logic [31:0] p_data;
        logic [4:0]  p_idx;
        logic        p_last;
        exp_idx = first; first_n = -1; words = 0; stall_cnt = 0;
        ended = 0; prev_stall = 0; hs_last = 0;
        p_data = '0; p_idx = '0; p_last = 1'b0;
        reset = 1'b0; start_s[w] = 1'b1; abort_s[w] = 1'b0; ready_s[w] = 1'b1;
        n = 0;
        while (!ended && n < 400) begin
            @(negedge clk);
            n++;
            start_s[w] = 1'b0;
            abort_s[w] = 1'b0;
            if (n == 1) check($sformatf("dut%0d busy after start", w), busy_s[w], 1);
            if (hs_last) begin
                check($sformatf("dut%0d done after last handshake", w), done_s[w], 1);
                check($sformatf("dut%0d valid low in FIN", w), valid_s[w], 0);
                check($sformatf("dut%0d word count", w), words, 32 - first);
                if (!rand_rdy && stall_at < 0)
                    check($sformatf("dut%0d cycles first valid..done", w), n - first_n + 1, 2 * (32 - first));
                @(negedge clk);
                check($sformatf("dut%0d done one cycle", w), done_s[w], 0);
                check($sformatf("dut%0d idle after done", w), busy_s[w], 0);
                check($sformatf("dut%0d addr 0 in idle", w), addr_s[w], 0);
                ended = 1;
            end else begin
                if (done_s[w]) check($sformatf("dut%0d early done", w), done_s[w], 0);
                if (valid_s[w]) begin
                    if (first_n < 0) begin
                        first_n = n;
                        check($sformatf("dut%0d first valid latency", w), n, 2);
                    end
                    if (prev_stall) begin
                        check($sformatf("dut%0d stall data stable", w), data_s[w], p_data);
                        check($sformatf("dut%0d stall index stable", w), oidx_s[w], p_idx);
                        check($sformatf("dut%0d stall last stable", w), last_s[w], p_last);
                    end else if (exp_idx < 32) begin
                        check($sformatf("dut%0d index", w), oidx_s[w], exp_idx);
                        check($sformatf("dut%0d data x%0d", w, exp_idx), data_s[w], ref_rf[w][exp_idx]);
                        check($sformatf("dut%0d last x%0d", w, exp_idx), last_s[w], exp_idx == 31);
                    end else begin
                        check($sformatf("dut%0d word past end", w), oidx_s[w], 31);
                    end
                    p_data = data_s[w]; p_idx = oidx_s[w]; p_last = last_s[w];
                    if (wr5 && oidx_s[w] == 5'd3 && !prev_stall) begin
                        rf_mem[w][5] = 32'hDEAD_BEEF;
                        ref_rf[w][5] = 32'hDEAD_BEEF;
                    end
                    if (wr5 && oidx_s[w] == 5'd5 && !prev_stall)
                        check($sformatf("dut%0d x5 late write seen", w), data_s[w], 32'hDEAD_BEEF);
                    if (int'(oidx_s[w]) == abort_at) begin
                        abort_s[w] = 1'b1;
                        ready_s[w] = 1'b1;
                        @(negedge clk);
                        abort_s[w] = 1'b0;
                        check($sformatf("dut%0d valid after abort", w), valid_s[w], 0);
                        check($sformatf("dut%0d busy after abort", w), busy_s[w], 0);
                        check($sformatf("dut%0d no done on abort", w), done_s[w], 0);
                        ended = 1;
                    end else if (int'(oidx_s[w]) == reset_at) begin
                        reset = 1'b1;
                        @(negedge clk);
                        reset = 1'b0;
                        check($sformatf("dut%0d reset out_data", w), data_s[w], 0);
                        check($sformatf("dut%0d reset out_index", w), oidx_s[w], 0);
                        check($sformatf("dut%0d reset out_last", w), last_s[w], 0);
                        check($sformatf("dut%0d reset out_valid", w), valid_s[w], 0);
                        check($sformatf("dut%0d reset busy", w), busy_s[w], 0);
                        check($sformatf("dut%0d reset done", w), done_s[w], 0);
                        check($sformatf("dut%0d reset rf_addr", w), addr_s[w], 0);
                        ended = 1;
                    end else begin
                        if (int'(oidx_s[w]) == stall_at && stall_cnt < 5) begin
                            ready_s[w] = 1'b0;
                            stall_cnt++;
                        end else if (rand_rdy) begin
                            ready_s[w] = 1'($urandom_range(0, 1));
                        end else begin
                            ready_s[w] = 1'b1;
                        end
                        prev_stall = !ready_s[w];
                        if (ready_s[w]) begin
                            words++;
                            if (exp_idx == 31) hs_last = 1;
                            exp_idx++;
                        end
                        // start while busy must be ignored
                        start_s[w] = 1'($urandom_range(0, 1));
                    end
                end else if (busy_s[w]) begin
                    start_s[w] = 1'($urandom_range(0, 1));
                end
            end
        end
        if (!ended) begin
            vectors++;
            miscompares++;
            $display("FAIL dut%0d timeout: dump did not finish within %0d cycles, required completion", w, n);
        end
        start_s[w] = 1'b0;
        abort_s[w] = 1'b0;
        ready_s[w] = 1'b1;
    endtask

    initial begin
        for (int w = 0; w < 2; w++) begin
            start_s[w] = 1'b0;
            abort_s[w] = 1'b0;
            ready_s[w] = 1'b1;
            for (int i = 0; i < 32; i++) begin
                rf_mem[w][i] = 32'h1000_0000 + 32'(i);
                ref_rf[w][i] = 32'h1000_0000 + 32'(i);
            end
        end

        // rst st ab rdy | busy valid done addr | chk data index last
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0,         5'd0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0,         5'd0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0,         5'd0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 32'h1000_0000, 5'd0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 32'h1000_0000, 5'd0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 32'h1000_0000, 5'd0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0,         5'd0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0,         5'd0, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0,         5'd0, 1'b0};

        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            reset      = tbl[i].rst;
            start_s[0] = tbl[i].st;
            abort_s[0] = tbl[i].ab;
            ready_s[0] = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("row%0d busy", i),    busy_s[0],  tbl[i].exp_busy);
            check($sformatf("row%0d valid", i),   valid_s[0], tbl[i].exp_valid);
            check($sformatf("row%0d done", i),    done_s[0],  tbl[i].exp_done);
            check($sformatf("row%0d rf_addr", i), addr_s[0],  tbl[i].exp_addr);
            if (tbl[i].chk_out) begin
                check($sformatf("row%0d out_data", i),  data_s[0], tbl[i].exp_data);
                check($sformatf("row%0d out_index", i), oidx_s[0], tbl[i].exp_index);
                check($sformatf("row%0d out_last", i),  last_s[0], tbl[i].exp_last);
            end
        end
        reset = 1'b0;
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        @(negedge clk);

        run_dump(0, 0, 0, -1, -1, -1, 0);
        run_dump(1, 1, 0, -1, -1, -1, 0);
        run_dump(0, 0, 0, 7, -1, -1, 0);
        run_dump(0, 0, 0, -1, 10, -1, 0);
        run_dump(0, 0, 0, -1, -1, -1, 0);
        run_dump(0, 0, 0, -1, -1, 20, 0);
        run_dump(0, 0, 0, -1, -1, -1, 1);

        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 32; i++) begin
                rf_mem[w][i] = $urandom;
                ref_rf[w][i] = rf_mem[w][i];
            end
        end
        run_dump(0, 0, 1, -1, -1, -1, 0);
        run_dump(1, 1, 1, 12, -1, -1, 0);
        run_dump(1, 1, 1, -1, -1, -1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 32, meaning the number of architectural registers walked.
REQ-002 The block SHALL have parameter SKIP_X0, default 0, meaning that when 1, register 0 is not emitted.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port start, input, 1 bit: request to begin a dump; sampled only in IDLE.
REQ-006 Port abort, input, 1 bit: cancel the dump in progress.
REQ-007 Port rf_addr, output, 5 bits: register-file read address; drives the A1 read port.
REQ-008 Port rf_data, input, 32 bits: combinational read data returned for rf_addr (RD1).
REQ-009 Port out_valid, output, 1 bit: out_data, out_index and out_last are valid.
REQ-010 Port out_ready, input, 1 bit: the consumer accepts the word this cycle.
REQ-011 Port out_data, output, 32 bits: captured register value.
REQ-012 Port out_index, output, 5 bits: register number of out_data.
REQ-013 Port out_last, output, 1 bit: this is the final word of the dump.
REQ-014 Port busy, output, 1 bit: high in every state except IDLE.
REQ-015 Port done, output, 1 bit: one-cycle pulse on normal completion.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, READ, SEND and FIN.
REQ-017 In IDLE with start=1, the FSM SHALL go to READ and load the index to FIRST, where FIRST = SKIP_X0 ? 1 : 0.
REQ-018 In READ, rf_addr SHALL equal the index; the block SHALL register rf_data into out_data and the index into out_index, set out_last = (index == NUM_REGS-1), and go to SEND.
REQ-019 In SEND, out_valid SHALL be 1; out_data, out_index and out_last SHALL stay stable until out_valid && out_ready.
REQ-020 On a SEND handshake with out_last=0, the index SHALL increment by 1 and the FSM SHALL go to READ.
REQ-021 On a SEND handshake with out_last=1, the FSM SHALL go to FIN.
REQ-022 In FIN, done SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-023 Latency: start at cycle N SHALL give the first out_valid at cycle N+2.
REQ-024 With out_ready held at 1, the block SHALL emit one word every 2 cycles.
REQ-025 A dump SHALL emit NUM_REGS - FIRST words with strictly ascending out_index and no gaps or repeats.
REQ-026 start SHALL be ignored in READ, SEND and FIN.
REQ-027 abort=1 in any non-IDLE state SHALL force IDLE next cycle, with out_valid=0 and no done pulse.
REQ-028 abort takes priority over a same-cycle handshake.
REQ-029 Start and abort high in the same IDLE cycle SHALL leave the FSM in IDLE.
REQ-030 The snapshot is not atomic: each word SHALL reflect register-file contents at its own READ cycle, including any write committed before that edge.
REQ-031 out_valid SHALL be 0 in IDLE, READ and FIN.
REQ-032 rf_addr SHALL hold the index in every state (0 in IDLE).
REQ-033 Index arithmetic SHALL be 5-bit with no wrap, because the terminal compare stops at NUM_REGS-1.

Reset
REQ-034 reset=1 at a clock edge SHALL, at that edge, set the state to IDLE and the index to 0.
REQ-035 reset SHALL, at the same edge, clear out_data, out_index, out_last, out_valid, busy and done to 0; this holds mid-dump, with no done pulse.
REQ-036 reset SHALL override start, abort and out_ready.

Structure
REQ-037 A shared package SHALL hold the FSM state encoding, the REG_ADDR_W=5 constant and the NUM_REGS default; the register file and this block both use the address width from it.
REQ-038 The block SHALL be a single module with no sub-module; it instantiates no register storage and connects externally to the register file's first read port.

Verification
REQ-039 The bench SHALL preload x0..x31 = 0x1000_0000+i with SKIP_X0=0 and out_ready=1, pulse start, and check 32 words with index 0..31, data 0x1000_0000+i, out_last only on index 31, done 1 cycle after the last handshake, and 64 cycles from the first valid to done.
REQ-040 The bench SHALL set SKIP_X0=1 and check 31 words with index 1..31 and first data 0x1000_0001.
REQ-041 The bench SHALL drive out_ready low for 5 cycles on index 7 and check out_data and index stay stable, with no skip or duplicate afterward.
REQ-042 The bench SHALL assert abort during SEND of index 10 and check out_valid=0 next cycle, busy=0 and no done; a new start SHALL then restart at index 0.
REQ-043 The bench SHALL assert reset mid-dump (index 20) and check all outputs are 0 at the next edge, with start pulses during busy ignored.
REQ-044 The bench SHALL write x5=0xDEAD_BEEF while index 3 is in SEND and check that word 5 returns 0xDEAD_BEEF.
